// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_ctrl
// Brief    : Sequential signed Booth multiply / restoring divide engine that
//            owns the HI/LO pair. Optional macro: MULTDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_write,
    output logic             lo_write
);

    localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_mult = 3'd1;
    localparam logic [2:0] c_div  = 3'd2;
    localparam logic [2:0] c_fix  = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH+1:0]   r_p_hi;   // Booth upper half (two guard bits) / divide remainder
    logic [WIDTH-1:0]   r_p_lo;   // Booth lower half / divide quotient
    logic               r_q;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic               r_hi_write;
    logic               r_lo_write;
    logic [WIDTH-1:0]   r_hi_out;
    logic [WIDTH-1:0]   r_lo_out;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH+1:0]   w_a_ext;
    logic [WIDTH+1:0]   w_booth_sum;
    logic [WIDTH+1:0]   w_booth_hi;
    logic [WIDTH-1:0]   w_booth_lo;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_signed;
    logic [WIDTH-1:0]   w_rem_signed;
    logic               w_early;

    assign w_a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    assign w_b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    assign w_a_ext = {{2{r_a[WIDTH-1]}}, r_a};

    always_comb begin
        w_booth_sum = r_p_hi;
        case ({r_p_lo[0], r_q})
            2'b01:   w_booth_sum = r_p_hi + w_a_ext;
            2'b10:   w_booth_sum = r_p_hi - w_a_ext;
            default: w_booth_sum = r_p_hi;
        endcase
    end

    assign w_booth_hi = {w_booth_sum[WIDTH+1], w_booth_sum[WIDTH+1:1]};
    assign w_booth_lo = {w_booth_sum[0], r_p_lo[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one bit more than the divisor
    assign w_shift      = {r_p_hi[WIDTH-1:0], r_p_lo[WIDTH-1]};
    assign w_diff       = {1'b0, w_shift} - {2'b00, r_b};
    assign w_fits       = ~w_diff[WIDTH+1];
    assign w_rem_next   = w_fits ? w_diff[WIDTH:0] : w_shift;
    assign w_quo_next   = {r_p_lo[WIDTH-2:0], w_fits};
    assign w_quo_signed = (r_a_neg ^ r_b_neg) ? -r_p_lo : r_p_lo;
    assign w_rem_signed = r_a_neg ? -r_p_hi[WIDTH-1:0] : r_p_hi[WIDTH-1:0];

`ifdef MULTDIV_EARLY_OUT_EN
    assign w_early = (a_in == '0) || (b_in == '0);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_p_hi     <= '0;
            r_p_lo     <= '0;
            r_q        <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_write <= 1'b0;
            r_lo_write <= 1'b0;
            r_hi_out   <= '0;
            r_lo_out   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_write <= 1'b0;
            r_lo_write <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_p_hi  <= '0;
                        r_q     <= 1'b0;
                        r_a_neg <= a_in[WIDTH-1];
                        r_b_neg <= b_in[WIDTH-1];
                        r_busy  <= 1'b1;
                        if (!op && w_early) begin
                            r_state    <= c_done;
                            r_done     <= 1'b1;
                            r_hi_write <= 1'b1;
                            r_lo_write <= 1'b1;
                            r_hi_out   <= '0;
                            r_lo_out   <= '0;
                        end else if (!op) begin
                            r_state <= c_mult;
                            r_a     <= a_in;
                            r_p_lo  <= b_in;
                        end else if (b_in == '0) begin
                            r_state    <= c_done;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= c_div;
                            r_b     <= w_b_mag;
                            r_p_lo  <= w_a_mag;
                        end
                    end
                end
                c_mult: begin
                    r_p_hi <= w_booth_hi;
                    r_p_lo <= w_booth_lo;
                    r_q    <= r_p_lo[0];
                    r_cnt  <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state    <= c_done;
                        r_done     <= 1'b1;
                        r_hi_write <= 1'b1;
                        r_lo_write <= 1'b1;
                        r_hi_out   <= w_booth_hi[WIDTH-1:0];
                        r_lo_out   <= w_booth_lo;
                    end
                end
                c_div: begin
                    r_p_hi <= {1'b0, w_rem_next};
                    r_p_lo <= w_quo_next;
                    r_cnt  <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state <= c_fix;
                    end
                end
                c_fix: begin
                    r_state    <= c_done;
                    r_done     <= 1'b1;
                    r_hi_write <= 1'b1;
                    r_lo_write <= 1'b1;
                    r_hi_out   <= w_rem_signed;
                    r_lo_out   <= w_quo_signed;
                end
                c_done: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi_out   = r_hi_out;
    assign lo_out   = r_lo_out;
    assign hi_write = r_hi_write;
    assign lo_write = r_lo_write;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_ctrl
// Brief    : Scoreboard bench for mult_div_ctrl against a 64-bit arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_ctrl;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         start  = 1'b0;
    logic         op     = 1'b0;
    logic [W-1:0] a_in   = '0;
    logic [W-1:0] b_in   = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         hi_write;
    logic         lo_write;

    mult_div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .hi_write (hi_write),
        .lo_write (lo_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
                end else begin
                    m_e = sb_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(m_e.cyc));
                    check("div_zero", {63'd0, div_zero}, {63'd0, m_e.dz});
                    check("hi_write", {63'd0, hi_write}, {63'd0, !m_e.dz});
                    check("lo_write", {63'd0, lo_write}, {63'd0, !m_e.dz});
                    check("hi_out", {32'd0, hi_out}, {32'd0, m_e.hi});
                    check("lo_out", {32'd0, lo_out}, {32'd0, m_e.lo});
                end
            end else begin
                check("idle_strobes", {61'd0, div_zero, hi_write, lo_write}, 64'd0);
            end
        end
    end

    task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at);
        exp_t   e;
        int     lat;
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op_i) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            lat  = 32;
`ifdef MULTDIV_EARLY_OUT_EN
            if (a == 0 || b == 0) lat = 0;
`endif
        end else if (b == 0) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dz = 1'b1;
            lat  = 0;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
            lat  = 33;
        end
        @(negedge clk);
        e.cyc = cyc + 1 + lat;
        sb_q.push_back(e);
        start = 1'b1;
        op    = op_i;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        op    = 1'($urandom_range(0, 1));
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_hi", {32'd0, hi_out}, 64'd0);
                check("rst_lo", {32'd0, lo_out}, 64'd0);
                sb_q.delete();
                last_hi = '0;
                last_lo = '0;
                @(negedge clk);
                check("rst_no_done", {61'd0, done, hi_write, lo_write}, 64'd0);
                rst_n = 1'b1;
                return;
            end
            check("busy", {63'd0, busy}, 64'd1);
            start = (k == poke_at);
            if (k == poke_at) begin
                op   = 1'b1;
                a_in = $urandom;
                b_in = $urandom;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_after", {63'd0, busy}, 64'd0);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        if (!e.dz) begin
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_strobes", {60'd0, done, div_zero, hi_write, lo_write}, 64'd0);
        check("reset_hi", {32'd0, hi_out}, 64'd0);
        check("reset_lo", {32'd0, lo_out}, 64'd0);
        rst_n = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(1'b1, 32'd5, 32'd0, -1, -1);
        run_op(1'b0, 32'd3, 32'd4, 10, -1);
        run_op(1'b0, 32'd3, 32'd4, -1, 15);
        run_op(1'b0, 32'd2, 32'd2, -1, -1);
        run_op(1'b0, 32'd0, 32'd123, -1, -1);
        run_op(1'b1, 32'd0, 32'hFFFF_FFF9, -1, -1);

        for (int i = 0; i < 40; i++) begin
            logic        rop;
            logic [31:0] ra, rb;
            rop = 1'($urandom_range(0, 1));
            ra  = pick();
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
            run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got simulation still running expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
